// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-level AXI-Stream round-robin arbiter.
// rr_pick works on a fixed MAX_SRC-wide request vector so any arbiter up to 16 ports can reuse it.
package axis_arb_pkg;

  localparam int MAX_SRC = 16;
  localparam int MAX_GW  = $clog2(MAX_SRC);

  typedef enum logic {IDLE, LOCK} arb_state_e;

  // Offset n is the previous owner itself, so it only wins when it is the sole requester.
  function automatic logic [MAX_GW-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                                input logic [MAX_GW-1:0]  last,
                                                input int                 n);
    logic [MAX_GW-1:0] r;
    int k;
    r = last;
    for (int i = MAX_SRC; i >= 1; i--) begin
      if (i <= n) begin
        k = (int'(last) + i) % n;
        if (req[k[MAX_GW-1:0]]) r = k[MAX_GW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin priority encoder: the search starts just after i_last and wraps.
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int GW = $clog2(N);

  logic [MAX_SRC-1:0] w_req;
  logic [MAX_GW-1:0]  w_last;
  logic [MAX_GW-1:0]  w_pick;

  always_comb begin
    w_req          = '0;
    w_req[N-1:0]   = i_req;
    w_last         = '0;
    w_last[GW-1:0] = i_last;
  end

  assign w_pick  = rr_pick(w_req, w_last, N);
  assign o_valid = |i_req;
  assign o_idx   = w_pick[GW-1:0];

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter: NUM_SRC sources share one master port.
// The grant is held from arbitration until the owner's TLAST beat is accepted.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_WIDTH = 8,
  parameter int TDEST_WIDTH = 8,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 8
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [NUM_SRC-1:0]                 S_TVALID,
  output logic [NUM_SRC-1:0]                 S_TREADY,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0]     S_TDATA,
  input  logic [NUM_SRC*TDATA_WIDTH/8-1:0]   S_TKEEP,
  input  logic [NUM_SRC*TDATA_WIDTH/8-1:0]   S_TSTRB,
  input  logic [NUM_SRC-1:0]                 S_TLAST,
  input  logic [NUM_SRC*TID_WIDTH-1:0]       S_TID,
  input  logic [NUM_SRC*TDEST_WIDTH-1:0]     S_TDEST,
  input  logic [NUM_SRC*TUSER_WIDTH-1:0]     S_TUSER,
  output logic                               M_TVALID,
  input  logic                               M_TREADY,
  output logic [TDATA_WIDTH-1:0]             M_TDATA,
  output logic [TDATA_WIDTH/8-1:0]           M_TKEEP,
  output logic [TDATA_WIDTH/8-1:0]           M_TSTRB,
  output logic                               M_TLAST,
  output logic [TID_WIDTH-1:0]               M_TID,
  output logic [TDEST_WIDTH-1:0]             M_TDEST,
  output logic [TUSER_WIDTH-1:0]             M_TUSER,
  output logic [$clog2(NUM_SRC)-1:0]         GRANT,
  output logic                               BUSY
);
  localparam int GW = $clog2(NUM_SRC);
  localparam int KW = TDATA_WIDTH / 8;

  arb_state_e       r_state;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    r_last;
  logic             w_pick_vld;
  logic [GW-1:0]    w_pick_idx;
  logic             w_busy;

  logic [TDATA_WIDTH-1:0] w_data [NUM_SRC];
  logic [KW-1:0]          w_keep [NUM_SRC];
  logic [KW-1:0]          w_strb [NUM_SRC];
  logic [TID_WIDTH-1:0]   w_id   [NUM_SRC];
  logic [TDEST_WIDTH-1:0] w_dest [NUM_SRC];
  logic [TUSER_WIDTH-1:0] w_user [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_data[g] = S_TDATA[g*TDATA_WIDTH +: TDATA_WIDTH];
    assign w_keep[g] = S_TKEEP[g*KW +: KW];
    assign w_strb[g] = S_TSTRB[g*KW +: KW];
    assign w_id[g]   = S_TID[g*TID_WIDTH +: TID_WIDTH];
    assign w_dest[g] = S_TDEST[g*TDEST_WIDTH +: TDEST_WIDTH];
    assign w_user[g] = S_TUSER[g*TUSER_WIDTH +: TUSER_WIDTH];
  end

  axis_rr_picker #(.N(NUM_SRC)) u_pick (
    .i_req   (S_TVALID),
    .i_last  (r_last),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  assign w_busy = (r_state == LOCK);
  assign BUSY   = w_busy;
  assign GRANT  = r_grant;

  // Everything is gated by the state register, so an async reset clears the port at once.
  always_comb begin
    S_TREADY = '0;
    M_TVALID = 1'b0;
    M_TDATA  = '0;
    M_TKEEP  = '0;
    M_TSTRB  = '0;
    M_TLAST  = 1'b0;
    M_TID    = '0;
    M_TDEST  = '0;
    M_TUSER  = '0;
    if (w_busy) begin
      S_TREADY[r_grant] = M_TREADY;
      M_TVALID = S_TVALID[r_grant];
      M_TDATA  = w_data[r_grant];
      M_TKEEP  = w_keep[r_grant];
      M_TSTRB  = w_strb[r_grant];
      M_TLAST  = S_TLAST[r_grant];
      M_TID    = w_id[r_grant];
      M_TDEST  = w_dest[r_grant];
      M_TUSER  = w_user[r_grant];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= GW'(NUM_SRC - 1);
    end else begin
      case (r_state)
        IDLE: if (w_pick_vld) begin
          r_grant <= w_pick_idx;
          r_state <= LOCK;
        end
        LOCK: if (M_TVALID && M_TREADY && M_TLAST) begin
          r_last  <= r_grant;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
